// File: rtl/cv_pkg.sv
// Shared encodings for the CV regulator supervisor: FSM states, fault codes, default width.
package cv_pkg;

    localparam int CV_DATA_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_REGULATE = 3'd2,
        ST_FAULT    = 3'd3
    } cv_state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_OV      = 2'b01;
    localparam logic [1:0] FC_UV      = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

endpackage

// File: rtl/cv_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module cv_tick_gen #(
    parameter int TICK_DIV = 6501
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] div_q, div_d;

    always_comb begin
        tick  = (div_q == W'(TICK_DIV - 1));
        div_d = tick ? '0 : div_q + W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

endmodule

// File: rtl/cv_supervisor.sv
// Soft-start / protection sequencer: ramps the regulator set point, tracks power-good,
// and latches OV / UV / settle-timeout faults with a bounded number of automatic retries.
module cv_supervisor
    import cv_pkg::*;
#(
    parameter int DATA_W         = CV_DATA_W,
    parameter int TICK_DIV       = 6501,
    parameter int RAMP_STEP      = 1,
    parameter int OV_MARGIN      = 200,
    parameter int UV_MARGIN      = 200,
    parameter int PG_MARGIN      = 15,
    parameter int PG_TICKS       = 32,
    parameter int UV_TICKS       = 16,
    parameter int SETTLE_TICKS   = 2048,
    parameter int COOLDOWN_TICKS = 1000,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] voltage,
    input  logic              voltage_valid,
    output logic [DATA_W-1:0] set_point,
    output logic              reg_resetn,
    output logic              power_good,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [1:0]        retry_count,
    output logic [2:0]        state
);

    localparam int XW  = DATA_W + 1;
    localparam int PGW = $clog2(PG_TICKS + 1);
    localparam int UVW = $clog2(UV_TICKS + 1);
    localparam int STW = $clog2(SETTLE_TICKS + 1);
    localparam int CDW = $clog2(COOLDOWN_TICKS + 1);

    logic tick;

    cv_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    cv_state_e         state_q, state_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] v_q, v_d;
    logic              rn_q, rn_d;
    logic              pg_q, pg_d;
    logic              flt_q, flt_d;
    logic [1:0]        fc_q, fc_d;
    logic [1:0]        rc_q, rc_d;
    logic [PGW-1:0]    pgc_q, pgc_d;
    logic [UVW-1:0]    uvc_q, uvc_d;
    logic [STW-1:0]    stc_q, stc_d;
    logic [CDW-1:0]    cdc_q, cdc_d;

    // Comparisons run one bit wider so threshold sums never wrap.
    logic [DATA_W-1:0] v_cur, sp_up, sp_dn;
    logic [XW-1:0]     v_x, sp_x, tg_x;
    logic              ov_hit, uv_now, in_win, uv_fault, to_fault;

    always_comb begin
        v_d    = voltage_valid ? voltage : v_q;
        v_cur  = v_d;
        v_x    = {1'b0, v_cur};
        sp_x   = {1'b0, sp_q};
        tg_x   = {1'b0, target};
        ov_hit = voltage_valid && ({1'b0, voltage} > sp_x + XW'(OV_MARGIN));
        uv_now = (v_x + XW'(UV_MARGIN)) < sp_x;
        in_win = (v_x <= sp_x + XW'(PG_MARGIN)) && (v_x + XW'(PG_MARGIN) >= sp_x);
        sp_up  = (sp_x + XW'(RAMP_STEP) >= tg_x) ? target : sp_q + DATA_W'(RAMP_STEP);
        sp_dn  = (tg_x + XW'(RAMP_STEP) >= sp_x) ? target : sp_q - DATA_W'(RAMP_STEP);
    end

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        pg_d     = pg_q;
        fc_d     = fc_q;
        rc_d     = rc_q;
        pgc_d    = pgc_q;
        uvc_d    = uvc_q;
        stc_d    = stc_q;
        cdc_d    = cdc_q;
        uv_fault = 1'b0;
        to_fault = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && target != '0) state_d = ST_RAMP;
            end

            ST_RAMP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ov_hit) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_OV;
                end else if (target < sp_q) begin
                    sp_d = target;
                end else if (sp_q == target) begin
                    state_d = ST_REGULATE;
                    pgc_d   = '0;
                    uvc_d   = '0;
                    stc_d   = '0;
                end else if (tick) begin
                    sp_d = sp_up;
                end
            end

            ST_REGULATE: begin
                if (tick) begin
                    if (target > sp_q)      sp_d = sp_up;
                    else if (target < sp_q) sp_d = sp_dn;
                end
                if (!in_win && (voltage_valid || tick)) begin
                    pgc_d = '0;
                    pg_d  = 1'b0;
                end else if (tick && !pg_q) begin
                    pgc_d = pgc_q + PGW'(1);
                    if (pgc_q == PGW'(PG_TICKS - 1)) pg_d = 1'b1;
                end
                if (tick) begin
                    uvc_d    = uv_now ? uvc_q + UVW'(1) : '0;
                    uv_fault = uv_now && (uvc_q == UVW'(UV_TICKS - 1));
                end
                if (tick && !pg_q) begin
                    stc_d    = stc_q + STW'(1);
                    to_fault = (stc_q == STW'(SETTLE_TICKS - 1));
                end

                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ov_hit) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_OV;
                end else if (uv_fault) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_UV;
                end else if (to_fault) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_TIMEOUT;
                end
            end

            ST_FAULT: begin
                // Cooldown counter parks at its last value once retries are exhausted.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (cdc_q == CDW'(COOLDOWN_TICKS - 1)) begin
                        if (rc_q < 2'(MAX_RETRY)) begin
                            state_d = ST_RAMP;
                            rc_d    = rc_q + 2'd1;
                            cdc_d   = '0;
                        end
                    end else begin
                        cdc_d = cdc_q + CDW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE || state_d == ST_FAULT) sp_d = '0;
        if (state_d != ST_REGULATE) pg_d = 1'b0;
        if (state_d == ST_FAULT && state_q != ST_FAULT) cdc_d = '0;
        if (state_d == ST_IDLE) begin
            fc_d  = FC_NONE;
            rc_d  = '0;
            pgc_d = '0;
            uvc_d = '0;
            stc_d = '0;
            cdc_d = '0;
        end

        rn_d  = (state_d == ST_RAMP) || (state_d == ST_REGULATE);
        flt_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sp_q    <= '0;
            v_q     <= '0;
            rn_q    <= 1'b0;
            pg_q    <= 1'b0;
            flt_q   <= 1'b0;
            fc_q    <= FC_NONE;
            rc_q    <= '0;
            pgc_q   <= '0;
            uvc_q   <= '0;
            stc_q   <= '0;
            cdc_q   <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            v_q     <= v_d;
            rn_q    <= rn_d;
            pg_q    <= pg_d;
            flt_q   <= flt_d;
            fc_q    <= fc_d;
            rc_q    <= rc_d;
            pgc_q   <= pgc_d;
            uvc_q   <= uvc_d;
            stc_q   <= stc_d;
            cdc_q   <= cdc_d;
        end
    end

    assign state       = state_q;
    assign set_point   = sp_q;
    assign reg_resetn  = rn_q;
    assign power_good  = pg_q;
    assign fault       = flt_q;
    assign fault_code  = fc_q;
    assign retry_count = rc_q;

endmodule
